// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access.
// Faulting accesses (misaligned or out of range) complete normally but flag MemErr.
module dmem_responder #(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemErr,
   output logic        MemBusy
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [31:0] addr_q, wdata_q;
   logic        write_q, err_q;
   logic [31:0] mem [DEPTH];

   logic [31:0]   acc_addr, acc_wdata;
   logic          acc_write, acc_fault, enter_done;
   logic [AW-1:0] acc_idx;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (MemReq) state_nxt = (WAIT == 0) ? DONE : BUSY;
         BUSY:    if (cnt <= 4'd1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With WAIT=0 the capture edge is also the completion edge, so the live
   // request fields are used directly; otherwise the captured copy is used.
   always_comb begin
      enter_done = (state_nxt == DONE) && (state != DONE);
      acc_addr   = (state == IDLE) ? Addr      : addr_q;
      acc_wdata  = (state == IDLE) ? WriteData : wdata_q;
      acc_write  = (state == IDLE) ? MemWrite  : write_q;
      acc_fault  = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:AW+2]);
      acc_idx    = acc_addr[AW+1:2];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         ReadData <= 32'd0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && MemReq) begin
            addr_q  <= Addr;
            wdata_q <= WriteData;
            write_q <= MemWrite;
            cnt     <= 4'(WAIT);
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_done) begin
            err_q <= acc_fault;
            if (acc_fault)       ReadData <= 32'd0;
            else if (!acc_write) ReadData <= mem[acc_idx];
         end
      end
   end

   // Array is deliberately not reset; contents survive reset.
   always_ff @(posedge clk) begin
      if (enter_done && acc_write && !acc_fault)
         mem[acc_idx] <= acc_wdata;
   end

   assign MemReady = (state == DONE);
   assign MemErr   = MemReady && err_q;
   assign MemBusy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, random traffic against a
// word-array reference model, and hand sequences for reset abort and WAIT=0.
module tb_dmem_responder;
   localparam int DEPTH = 64;
   localparam int WAIT  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReq, MemWrite;
   logic [31:0] Addr, WriteData, ReadData;
   logic        MemReady, MemErr, MemBusy;

   logic        req0, we0;
   logic [31:0] addr0, wd0, rd0;
   logic        rdy0, err0, busy0;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl_mem [DEPTH];
   logic [31:0] mdl_rd;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
      .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
      .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
      .MemReady(MemReady), .MemErr(MemErr), .MemBusy(MemBusy));

   dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (
      .clk(clk), .reset(reset), .MemReq(req0), .MemWrite(we0),
      .Addr(addr0), .WriteData(wd0), .ReadData(rd0),
      .MemReady(rdy0), .MemErr(err0), .MemBusy(busy0));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   function automatic logic [31:0] pre(input int i);
      return 32'hC0DE0000 | 32'(i);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: faults leave memory alone and zero the read register.
   task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] erd, output logic eerr);
      eerr = ((a % 32'd4) != 32'd0) || (a >= 32'(4 * DEPTH));
      if (eerr)     mdl_rd = 32'd0;
      else if (we)  mdl_mem[int'(a / 32'd4)] = wd;
      else          mdl_rd = mdl_mem[int'(a / 32'd4)];
      erd = mdl_rd;
   endtask

   // Called at a falling edge with the DUT idle; returns at a falling edge idle.
   task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input bit alt, input logic [31:0] alt_a, input logic [31:0] alt_wd,
                          output logic [31:0] rd, output logic err);
      int lat;
      lat = 0;
      rd  = 32'd0;
      err = 1'b0;
      MemReq = 1'b1; MemWrite = we; Addr = a; WriteData = wd;
      @(posedge clk); #1;
      MemReq = alt;
      if (alt) begin
         Addr = alt_a; WriteData = alt_wd; MemWrite = ~we;
      end
      for (int k = 0; k < 20 && lat == 0; k++) begin
         @(negedge clk);
         chk("busy_inflight", 32'(MemBusy), 32'd1);
         if (MemReady) begin
            lat = k + 1;
            rd  = ReadData;
            err = MemErr;
            MemReq = 1'b0;
         end else begin
            chk("err_unqualified", 32'(MemErr), 32'd0);
         end
      end
      chk("latency", 32'(lat), 32'(WAIT + 1));
      @(negedge clk);
      chk("ready_one_cycle", 32'(MemReady), 32'd0);
      chk("busy_back_idle", 32'(MemBusy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [11];
      vec_t        seq0 [6];
      logic [31:0] rd, erd, old2;
      logic        err, eerr, we;
      logic [31:0] a, wd;

      tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b0, 32'h13,       32'h0,        32'h0,        1'b1};
      tbl[3]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
      tbl[4]  = '{1'b0, 32'h0,        32'h0,        pre(0),       1'b0};
      tbl[5]  = '{1'b1, 32'h100,      32'h12345678, 32'h0,        1'b1};
      tbl[6]  = '{1'b0, 32'h0,        32'h0,        pre(0),       1'b0};
      tbl[7]  = '{1'b1, 32'h4,        32'h11112222, pre(0),       1'b0};
      tbl[8]  = '{1'b0, 32'h4,        32'h0,        32'h11112222, 1'b0};
      tbl[9]  = '{1'b0, 32'hFC,       32'h0,        pre(63),      1'b0};
      tbl[10] = '{1'b0, 32'h80000000, 32'h0,        32'h0,        1'b1};

      seq0[0] = '{1'b1, 32'h0, 32'h11111111, 32'h0,        1'b0};
      seq0[1] = '{1'b1, 32'h4, 32'h22222222, 32'h0,        1'b0};
      seq0[2] = '{1'b0, 32'h0, 32'h0,        32'h11111111, 1'b0};
      seq0[3] = '{1'b0, 32'h4, 32'h0,        32'h22222222, 1'b0};
      seq0[4] = '{1'b0, 32'h2, 32'h0,        32'h0,        1'b1};
      seq0[5] = '{1'b0, 32'h4, 32'h0,        32'h22222222, 1'b0};

      reset = 1'b0; MemReq = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0;
      mdl_rd = 32'd0;
      #1;
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_ready", 32'(MemReady), 32'd0);
      chk("rst_err", 32'(MemErr), 32'd0);
      chk("rst_busy", 32'(MemBusy), 32'd0);
      chk("rst_busy0", 32'(busy0), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Preload every word; the first request is captured on the first edge after release.
      for (int i = 0; i < DEPTH; i++) begin
         model(1'b1, 32'(4 * i), pre(i), erd, eerr);
         run_txn(1'b1, 32'(4 * i), pre(i), 1'b0, '0, '0, rd, err);
         chk("preload_err", 32'(err), 32'd0);
      end

      for (int i = 0; i < 11; i++) begin
         model(tbl[i].we, tbl[i].addr, tbl[i].wdata, erd, eerr);
         run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, '0, '0, rd, err);
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      end

      // Request fields disturbed mid-transaction must not leak in.
      model(1'b1, 32'h24, 32'hA5A5A5A5, erd, eerr);
      run_txn(1'b1, 32'h24, 32'hA5A5A5A5, 1'b1, 32'h20, 32'h0, rd, err);
      chk("hold_store_err", 32'(err), 32'd0);
      model(1'b0, 32'h24, 32'h0, erd, eerr);
      run_txn(1'b0, 32'h24, 32'h0, 1'b0, '0, '0, rd, err);
      chk("hold_word9", rd, 32'hA5A5A5A5);
      model(1'b0, 32'h20, 32'h0, erd, eerr);
      run_txn(1'b0, 32'h20, 32'h0, 1'b0, '0, '0, rd, err);
      chk("hold_word8", rd, pre(8));

      for (int n = 0; n < 200; n++) begin
         we = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0:       a = $urandom();
            1:       a = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
            default: a = 32'($urandom_range(0, 63)) * 32'd4;
         endcase
         wd = $urandom();
         model(we, a, wd, erd, eerr);
         run_txn(we, a, wd, 1'($urandom_range(0, 1)), $urandom(), $urandom(), rd, err);
         chk("rand_err", 32'(err), 32'(eerr));
         chk("rand_rdata", rd, erd);
      end

      // Reset one cycle into BUSY of a store must abort it cleanly.
      old2 = mdl_mem[2];
      model(1'b0, 32'h10, 32'h0, erd, eerr);
      run_txn(1'b0, 32'h10, 32'h0, 1'b0, '0, '0, rd, err);
      chk("pre_abort_load", rd, erd);
      MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h8; WriteData = 32'hBAD0BAD0;
      @(posedge clk); #1;
      MemReq = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("abort_rdata", ReadData, 32'd0);
      chk("abort_ready", 32'(MemReady), 32'd0);
      chk("abort_err", 32'(MemErr), 32'd0);
      chk("abort_busy", 32'(MemBusy), 32'd0);
      mdl_rd = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_ready", 32'(MemReady), 32'd0);
      end
      model(1'b0, 32'h8, 32'h0, erd, eerr);
      run_txn(1'b0, 32'h8, 32'h0, 1'b0, '0, '0, rd, err);
      chk("abort_word2", rd, old2);

      // WAIT=0: request held high, transactions every other cycle.
      req0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         we0 = seq0[i].we; addr0 = seq0[i].addr; wd0 = seq0[i].wdata;
         @(negedge clk);
         chk($sformatf("w0_%0d_ready", i), 32'(rdy0), 32'd1);
         chk($sformatf("w0_%0d_busy", i), 32'(busy0), 32'd1);
         chk($sformatf("w0_%0d_err", i), 32'(err0), 32'(seq0[i].err));
         chk($sformatf("w0_%0d_rdata", i), rd0, seq0[i].rd);
         we0 = 1'b1; addr0 = 32'h0; wd0 = 32'hFFFFFFFF;
         @(negedge clk);
         chk($sformatf("w0_%0d_gap_ready", i), 32'(rdy0), 32'd0);
         chk($sformatf("w0_%0d_gap_busy", i), 32'(busy0), 32'd0);
      end
      req0 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
